// File: rtl/syncram_dp_be.sv
// -----------------------------------------------------------------------------
// syncram_dp_be: true dual-port synchronous RAM with per-byte write enables.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   address_a/_b            word address per port (DEPTH bits)
//   data_a/_b               write data per port (WIDTH bits)
//   byteen_a/_b             byte write enables, bit i covers bits 8i+7:8i
//   rden_a/_b, wren_a/_b    read / write requests
//   q_a/_b                  read data, held between q_valid pulses
//   q_valid_a/_b            one-cycle pulse, RD_LAT cycles after a read request
//   busy                    high while the post-reset clear sweeps the array
//   collision               pulse one cycle after a same-address overlapping dual write
//
// Dual writes to one address merge per byte with port A taking priority.
// Addresses >= WORDS drop writes and read back as zero.
// -----------------------------------------------------------------------------
module syncram_dp_be #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RDW_MODE   = 0,
    parameter int unsigned CLR_ON_RST = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DEPTH-1:0]   address_a,
    input  logic [DEPTH-1:0]   address_b,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    input  logic [WIDTH/8-1:0] byteen_a,
    input  logic [WIDTH/8-1:0] byteen_b,
    input  logic               rden_a,
    input  logic               rden_b,
    input  logic               wren_a,
    input  logic               wren_b,
    output logic [WIDTH-1:0]   q_a,
    output logic [WIDTH-1:0]   q_b,
    output logic               q_valid_a,
    output logic               q_valid_b,
    output logic               busy,
    output logic               collision
);

    localparam int unsigned NB = WIDTH / 8;
    localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [DEPTH:0] WordsL  = (DEPTH + 1)'(WORDS);
    localparam logic [AW-1:0]  LastIdx = AW'(WORDS - 1);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e           state_q;
    logic [AW-1:0]    cnt_q;
    logic [WIDTH-1:0] mem [WORDS];

    // Port-indexed views: index 0 is port A, index 1 is port B.
    logic [DEPTH-1:0] addr  [2];
    logic [WIDTH-1:0] wdata [2];
    logic [NB-1:0]    be    [2];
    logic [1:0]       rden;
    logic [1:0]       wren;

    assign addr[0]  = address_a;
    assign addr[1]  = address_b;
    assign wdata[0] = data_a;
    assign wdata[1] = data_b;
    assign be[0]    = byteen_a;
    assign be[1]    = byteen_b;
    assign rden     = {rden_b, rden_a};
    assign wren     = {wren_b, wren_a};

    logic             accept;
    logic [1:0]       in_range;
    logic [1:0]       we;
    logic [1:0]       re;
    logic [AW-1:0]    idx     [2];
    logic [WIDTH-1:0] rd_word [2];

    // Requests presented during the reset cycle are ignored as well.
    assign accept = (state_q == StReady) && !reset;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, addr[p]} < WordsL);
            idx[p]      = addr[p][AW-1:0];
            we[p]       = wren[p] & accept & in_range[p];
            re[p]       = rden[p] & accept;
        end
    end

    // Read word per port: either the stored word, or the word with this cycle's
    // writes merged in (B first, then A, so A owns overlapping bytes).
    always_comb begin
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] merged;
        for (int p = 0; p < 2; p++) begin
            word   = in_range[p] ? mem[idx[p]] : '0;
            merged = word;
            for (int w = 1; w >= 0; w--) begin
                if (we[w] && (addr[w] == addr[p])) begin
                    for (int i = 0; i < NB; i++) begin
                        if (be[w][i]) merged[8*i +: 8] = wdata[w][8*i +: 8];
                    end
                end
            end
            rd_word[p] = (RDW_MODE != 0) ? merged : word;
        end
    end

    // Array storage: the clear sweep owns the array while busy.
    always_ff @(posedge clock) begin
        if (state_q == StClear && !reset) begin
            mem[cnt_q] <= '0;
        end else begin
            // Port B is issued first so port A's later assignment wins a byte tie.
            for (int w = 1; w >= 0; w--) begin
                if (we[w]) begin
                    for (int i = 0; i < NB; i++) begin
                        if (be[w][i]) mem[idx[w]][8*i +: 8] <= wdata[w][8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= (CLR_ON_RST != 0) ? StClear : StReady;
            cnt_q   <= '0;
        end else if (state_q == StClear) begin
            if (cnt_q == LastIdx) begin
                state_q <= StReady;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    logic [WIDTH-1:0] s1_data_q [2];
    logic [WIDTH-1:0] q_q       [2];
    logic [1:0]       s1_valid_q;
    logic [1:0]       qv_q;
    logic             coll_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= '0;
            qv_q       <= '0;
            coll_q     <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p] <= '0;
                q_q[p]       <= '0;
            end
        end else begin
            coll_q <= accept && wren[0] && wren[1] && (addr[0] == addr[1]) &&
                      |(be[0] & be[1]);
            s1_valid_q <= re;
            for (int p = 0; p < 2; p++) begin
                if (re[p]) s1_data_q[p] <= rd_word[p];
            end
            if (RD_LAT == 1) begin
                qv_q <= re;
                for (int p = 0; p < 2; p++) begin
                    if (re[p]) q_q[p] <= rd_word[p];
                end
            end else begin
                qv_q <= s1_valid_q;
                for (int p = 0; p < 2; p++) begin
                    if (s1_valid_q[p]) q_q[p] <= s1_data_q[p];
                end
            end
        end
    end

    // Outputs read as zero for the whole cycle in which reset is asserted.
    assign q_a       = reset ? '0 : q_q[0];
    assign q_b       = reset ? '0 : q_q[1];
    assign q_valid_a = !reset && qv_q[0];
    assign q_valid_b = !reset && qv_q[1];
    assign collision = !reset && coll_q;
    assign busy      = (state_q == StClear);

endmodule

// File: doc/syncram_dp_be.md
SYNCRAM_DP_BE -- requirements
Module: syncram_dp_be

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 10: address width in bits.
REQ-003 SHALL have parameter WORDS, default 1024: number of words, at most 2^DEPTH.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0: read-during-write result, 0 = old data, 1 = new merged data.
REQ-006 SHALL have parameter CLR_ON_RST, default 1: 1 = zero the whole array after reset.
REQ-007 SHALL have port clock, input, 1: single clock, all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have ports address_a and address_b, input, DEPTH: port A and port B word address.
REQ-010 SHALL have ports data_a and data_b, input, WIDTH: write data.
REQ-011 SHALL have ports byteen_a and byteen_b, input, WIDTH/8: byte write enables, bit i covers bits 8i+7:8i.
REQ-012 SHALL have ports rden_a, rden_b, wren_a and wren_b, input, 1: read and write requests.
REQ-013 SHALL have ports q_a and q_b, output, WIDTH: read data.
REQ-014 SHALL have ports q_valid_a and q_valid_b, output, 1: one-cycle pulse marking new q data.
REQ-015 SHALL have port busy, output, 1: high while a clear is in progress; requests are ignored.
REQ-016 SHALL have port collision, output, 1: one-cycle pulse flagging a same-address, overlapping-byte dual write.

Function
REQ-017 SHALL use a two-state FSM:
- CLEAR: busy=1; a counter writes zero to address cnt each cycle, for cnt = 0 to WORDS-1; after cnt = WORDS-1 the FSM moves to READY.
- READY: busy=0; requests are accepted.
REQ-018 SHALL, in the cycle reset is high, enter CLEAR with cnt=0 if CLR_ON_RST=1, else enter READY with array contents untouched.
REQ-019 SHALL, when a port has wren=1 in READY, write only the bytes whose byteen bit is 1, with the write visible at the next edge; byteen all-zero writes nothing.
REQ-020 SHALL, when a port has rden=1 in READY, present the word on q exactly RD_LAT cycles later, with q_valid high in that same cycle.
REQ-021 SHALL hold q at its last value whenever q_valid is low.
REQ-022 SHALL resolve a read and a write to the same address in the same cycle (same port or cross-port) by RDW_MODE:
- 0: q returns the pre-write word.
- 1: q returns the word after all writes of that cycle are merged.
REQ-023 SHALL resolve dual writes to the same address per byte:
- a byte with byteen_a set takes data_a;
- a byte with only byteen_b set takes data_b.
REQ-024 SHALL pulse collision one cycle after any cycle with wren_a & wren_b & (address_a==address_b) & |(byteen_a & byteen_b).
REQ-025 SHALL, for an address >= WORDS, drop the write and return zero on the read, with q_valid still pulsed.
REQ-026 SHALL, while busy=1, ignore rden and wren, so no q_valid is produced for them and no array write occurs.
REQ-027 SHALL, in READY, let each port issue one request per cycle back-to-back with no bubbles, independently of the other port.

Reset
REQ-028 SHALL, in the cycle reset is high and the cycle after, drive q_a=0, q_b=0, q_valid_a=0, q_valid_b=0 and collision=0, and flush all read-pipeline stages.
REQ-029 SHALL drive busy=1 from the edge after reset is sampled until WORDS cycles later when CLR_ON_RST=1, and busy=0 when CLR_ON_RST=0.
REQ-030 SHALL restart the clear at cnt=0 if reset is reasserted mid-clear, discarding the partial progress.

Verification
REQ-031 SHALL cover a clear check with WORDS=16: reset for 1 cycle -> busy high for exactly 16 cycles; then reading all 16 addresses returns 0x00000000.
REQ-032 SHALL cover byte enables: write 0xAABBCCDD at address 5 with byteen=4'b1111, then 0x11223344 with byteen=4'b0101 -> read at address 5 returns 0xAA22CC44.
REQ-033 SHALL cover read-during-write: address 3 holds 0x0; port A writes 0xFFFF0000 while port B reads address 3 -> q_b=0x0 with RDW_MODE=0, 0xFFFF0000 with RDW_MODE=1, arriving RD_LAT cycles later.
REQ-034 SHALL cover dual-write collision: A writes 0x12345678 (byteen 4'b0011), B writes 0x9ABCDEF0 (byteen 4'b0110) to address 7 -> array holds 0x00BC5678 after a clear; collision pulses once.
REQ-035 SHALL cover streaming: RD_LAT=2, rden_a high for 8 cycles over addresses 0..7 -> 8 consecutive q_valid_a pulses starting 2 cycles after the first request, with data in order.
REQ-036 SHALL cover mid-clear reset: reset reasserted at cnt=9 with WORDS=16, and a read issued while busy -> busy stays high for 16 more cycles; the read produces no q_valid.
